// File: rtl/adc3wire_rx.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// adc3wire_rx
// ADC-side receiver for the 3-wire serial configuration bus. Frames of 32 bits
// arrive MSB first while adc3wire_strobe is low:
//   [31:20] header, [19:16] register address, [15:0] register data.
// A frame is accepted only if exactly 32 bits were clocked in and the header
// matches HEADER. An accepted frame writes its payload into a 16 x 16-bit
// register file. Any other frame is rejected and counted.
//
// Ports
//   sys_clk          system clock, at least 4x adc3wire_clk
//   sys_rst_n        asynchronous active-low reset
//   adc3wire_clk     serial clock (asynchronous to sys_clk)
//   adc3wire_data    serial data, valid on adc3wire_clk rising edge
//   adc3wire_strobe  active-low frame enable
//   rd_addr          register-file read address
//   rd_data          register-file contents at rd_addr (combinational)
//   wr_valid         one-cycle pulse, frame accepted and written
//   wr_addr          address of the last accepted frame (held)
//   wr_data          data of the last accepted frame (held)
//   frame_err        one-cycle pulse, frame rejected
//   err_count        rejected-frame count, saturating at 8'hFF
//   busy             registered inverse of the synchronised strobe
// -----------------------------------------------------------------------------
module adc3wire_rx #(
  parameter logic [11:0] HEADER      = 12'h001,
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] REG_RESET   = 16'h0000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        adc3wire_clk,
  input  logic        adc3wire_data,
  input  logic        adc3wire_strobe,
  input  logic [3:0]  rd_addr,
  output logic [15:0] rd_data,
  output logic        wr_valid,
  output logic [3:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        frame_err,
  output logic [7:0]  err_count,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam logic [5:0] FULL_COUNT    = 6'd32;
  localparam logic [5:0] OVERRUN_COUNT = 6'd33;

  state_t state, next_state;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic [SYNC_STAGES-1:0] strobe_sync;
  logic                   clk_prev;
  logic                   strobe_prev;
  logic [SYNC_STAGES:0]   primed;

  logic        clk_last;
  logic        data_last;
  logic        strobe_last;
  logic        clk_rise;
  logic        strobe_rise;
  logic        strobe_fall;
  logic        fall_pending;

  logic [31:0] shift_reg;
  logic [5:0]  bit_count;
  logic [15:0] regs [16];

  logic start_frame;
  logic shift_en;
  logic frame_ok;
  logic frame_bad;

  // Three identical synchroniser chains keep clk, data and strobe aligned
  // with each other. The strobe chain resets to the idle (high) level so a
  // reset does not look like a frame boundary.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      clk_sync    <= '0;
      data_sync   <= '0;
      strobe_sync <= '1;
      clk_prev    <= 1'b0;
      strobe_prev <= 1'b1;
    end else begin
      clk_sync    <= {clk_sync[SYNC_STAGES-2:0], adc3wire_clk};
      data_sync   <= {data_sync[SYNC_STAGES-2:0], adc3wire_data};
      strobe_sync <= {strobe_sync[SYNC_STAGES-2:0], adc3wire_strobe};
      clk_prev    <= clk_sync[SYNC_STAGES-1];
      strobe_prev <= strobe_sync[SYNC_STAGES-1];
    end
  end

  // primed fills with ones after reset release. Once its top bit is set both
  // the last sync stage and its delayed copy hold genuine samples, so a strobe
  // that was already low at release can no longer produce a false fall.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      primed <= '0;
    end else begin
      primed <= {primed[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign clk_last    = clk_sync[SYNC_STAGES-1];
  assign data_last   = data_sync[SYNC_STAGES-1];
  assign strobe_last = strobe_sync[SYNC_STAGES-1];
  assign clk_rise    = clk_last & ~clk_prev;
  assign strobe_rise = strobe_last & ~strobe_prev;
  assign strobe_fall = primed[SYNC_STAGES] & strobe_prev & ~strobe_last;

  // A strobe fall that lands in the CHECK cycle is remembered so that IDLE
  // starts the next frame one cycle later instead of dropping it.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      fall_pending <= 1'b0;
    end else if (state == CHECK) begin
      fall_pending <= strobe_fall;
    end else if (state == IDLE) begin
      fall_pending <= 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // In SHIFT a strobe rise takes priority over a coincident clk rise, so the
  // bit arriving with the end of the frame is not captured.
  always_comb begin
    next_state  = state;
    start_frame = 1'b0;
    shift_en    = 1'b0;
    frame_ok    = 1'b0;
    frame_bad   = 1'b0;
    case (state)
      IDLE: begin
        if (strobe_fall || fall_pending) begin
          start_frame = 1'b1;
          next_state  = SHIFT;
        end
      end
      SHIFT: begin
        if (strobe_rise) begin
          next_state = CHECK;
        end else if (clk_rise) begin
          shift_en = 1'b1;
        end
      end
      CHECK: begin
        next_state = IDLE;
        if (bit_count == FULL_COUNT && shift_reg[31:20] == HEADER) begin
          frame_ok = 1'b1;
        end else begin
          frame_bad = 1'b1;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // The bit counter stops at 33 so any frame longer than 32 bits stays
  // distinguishable from a correct one however many extra bits arrive.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      shift_reg <= '0;
      bit_count <= '0;
    end else if (start_frame) begin
      shift_reg <= '0;
      bit_count <= '0;
    end else if (shift_en) begin
      shift_reg <= {shift_reg[30:0], data_last};
      if (bit_count < OVERRUN_COUNT) begin
        bit_count <= bit_count + 6'd1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < 16; i++) begin
        regs[i] <= REG_RESET;
      end
    end else if (frame_ok) begin
      regs[shift_reg[19:16]] <= shift_reg[15:0];
    end
  end

  assign rd_data = regs[rd_addr];

  // Status outputs are registered on the same edge as the register-file write.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_valid  <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      frame_err <= 1'b0;
      err_count <= '0;
      busy      <= 1'b0;
    end else begin
      wr_valid  <= frame_ok;
      frame_err <= frame_bad;
      busy      <= ~strobe_last;
      if (frame_ok) begin
        wr_addr <= shift_reg[19:16];
        wr_data <= shift_reg[15:0];
      end
      if (frame_bad && err_count != 8'hFF) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_adc3wire_rx.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_adc3wire_rx
// Self-checking bench for adc3wire_rx. Drives serial frames at sys_clk/8 and
// compares the receiver against a frame-level reference model of the register
// file and the rejected-frame counter.
// -----------------------------------------------------------------------------
module tb_adc3wire_rx;

  localparam int          S      = 2;
  localparam logic [11:0] HDR    = 12'h001;
  localparam logic [15:0] RR     = 16'h0000;
  localparam int          HALF   = 4;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        adc3wire_clk;
  logic        adc3wire_data;
  logic        adc3wire_strobe;
  logic [3:0]  rd_addr;
  logic [15:0] rd_data;
  logic        wr_valid;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        frame_err;
  logic [7:0]  err_count;
  logic        busy;

  adc3wire_rx #(
    .HEADER(HDR),
    .SYNC_STAGES(S),
    .REG_RESET(RR)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst_n(sys_rst_n),
    .adc3wire_clk(adc3wire_clk),
    .adc3wire_data(adc3wire_data),
    .adc3wire_strobe(adc3wire_strobe),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .wr_valid(wr_valid),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .frame_err(frame_err),
    .err_count(err_count),
    .busy(busy)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  // Pulse monitor, sampled on the falling edge away from the active edge.
  int          wr_pulses = 0;
  int          err_pulses = 0;
  logic [3:0]  seen_addr = '0;
  logic [15:0] seen_data = '0;

  always @(negedge sys_clk) begin
    if (wr_valid === 1'b1) begin
      wr_pulses++;
      seen_addr = wr_addr;
      seen_data = wr_data;
    end
    if (frame_err === 1'b1) begin
      err_pulses++;
    end
  end

  // Reference model: what a receiver must do with a whole frame of n bits.
  logic [15:0] model_regs [16];
  int          model_err;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) model_regs[i] = RR;
    model_err = 0;
  endtask

  task automatic model_frame(input logic [63:0] bits, input int n, output bit is_write);
    logic [31:0] f;
    f = bits[31:0];
    is_write = (n == 32) && (f[31:20] == HDR);
    if (is_write) model_regs[f[19:16]] = f[15:0];
    else if (model_err < 255) model_err = model_err + 1;
  endtask

  // Serial bus drivers.
  task automatic clock_bits(input logic [63:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      adc3wire_data = bits[i];
      repeat (HALF) @(negedge sys_clk);
      adc3wire_clk = 1'b1;
      repeat (HALF) @(negedge sys_clk);
      adc3wire_clk = 1'b0;
    end
    repeat (HALF) @(negedge sys_clk);
  endtask

  task automatic shift_bits(input logic [63:0] bits, input int n);
    @(negedge sys_clk);
    adc3wire_strobe = 1'b0;
    repeat (HALF) @(negedge sys_clk);
    clock_bits(bits, n);
  endtask

  task automatic end_frame(input int gap);
    adc3wire_strobe = 1'b1;
    repeat (gap) @(negedge sys_clk);
  endtask

  task automatic send_frame(input logic [63:0] bits, input int n, input int gap);
    shift_bits(bits, n);
    end_frame(gap);
  endtask

  task automatic test_reset();
    sys_rst_n       = 1'b0;
    adc3wire_clk    = 1'b0;
    adc3wire_data   = 1'b0;
    adc3wire_strobe = 1'b1;
    rd_addr         = '0;
    model_reset();
    repeat (3) @(negedge sys_clk);
    checks++; if (wr_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr_valid: got %b expected 0", wr_valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_err: got %b expected 0", frame_err); end
    checks++; if (wr_addr !== 4'h0) begin errors++; $display("[TB] FAIL reset_wr_addr: got %h expected 0", wr_addr); end
    checks++; if (wr_data !== 16'h0) begin errors++; $display("[TB] FAIL reset_wr_data: got %h expected 0", wr_data); end
    checks++; if (err_count !== 8'h0) begin errors++; $display("[TB] FAIL reset_err_count: got %h expected 0", err_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    for (int a = 0; a < 16; a++) begin
      rd_addr = a[3:0];
      #1;
      checks++; if (rd_data !== model_regs[a]) begin errors++; $display("[TB] FAIL reset_reg%0d: got %h expected %h", a, rd_data, model_regs[a]); end
    end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (6) @(negedge sys_clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_single_write();
    int w0, e0;
    bit w;
    logic [63:0] f;
    f = {32'h0, HDR, 4'h9, 16'hdead};
    w0 = wr_pulses; e0 = err_pulses;
    send_frame(f, 32, 12);
    model_frame(f, 32, w);
    checks++; if (wr_pulses - w0 !== 1) begin errors++; $display("[TB] FAIL single_wr_pulses: got %0d expected 1", wr_pulses - w0); end
    checks++; if (err_pulses - e0 !== 0) begin errors++; $display("[TB] FAIL single_err_pulses: got %0d expected 0", err_pulses - e0); end
    checks++; if (seen_addr !== 4'h9) begin errors++; $display("[TB] FAIL single_wr_addr: got %h expected 9", seen_addr); end
    checks++; if (seen_data !== 16'hdead) begin errors++; $display("[TB] FAIL single_wr_data: got %h expected dead", seen_data); end
    checks++; if (wr_addr !== 4'h9) begin errors++; $display("[TB] FAIL single_wr_addr_held: got %h expected 9", wr_addr); end
    rd_addr = 4'h9; #1;
    checks++; if (rd_data !== model_regs[9]) begin errors++; $display("[TB] FAIL single_rd_data: got %h expected %h", rd_data, model_regs[9]); end
    checks++; if (err_count !== model_err[7:0]) begin errors++; $display("[TB] FAIL single_err_count: got %0d expected %0d", err_count, model_err); end
  endtask

  task automatic test_back_to_back();
    int w0;
    bit w;
    logic [63:0] f1, f2;
    f1 = {32'h0, HDR, 4'h8, 16'hbeef};
    f2 = {32'h0, HDR, 4'h3, 16'h1234};
    w0 = wr_pulses;
    send_frame(f1, 32, 2 * HALF);
    send_frame(f2, 32, 12);
    model_frame(f1, 32, w);
    model_frame(f2, 32, w);
    checks++; if (wr_pulses - w0 !== 2) begin errors++; $display("[TB] FAIL b2b_wr_pulses: got %0d expected 2", wr_pulses - w0); end
    checks++; if (seen_addr !== 4'h3 || seen_data !== 16'h1234) begin errors++; $display("[TB] FAIL b2b_last_write: got %h/%h expected 3/1234", seen_addr, seen_data); end
    rd_addr = 4'h8; #1;
    checks++; if (rd_data !== model_regs[8]) begin errors++; $display("[TB] FAIL b2b_reg8: got %h expected %h", rd_data, model_regs[8]); end
    rd_addr = 4'h3; #1;
    checks++; if (rd_data !== model_regs[3]) begin errors++; $display("[TB] FAIL b2b_reg3: got %h expected %h", rd_data, model_regs[3]); end
  endtask

  task automatic test_bad_header();
    int w0, e0;
    bit w;
    logic [63:0] f;
    f = {32'h0, 12'h002, 4'h4, 16'h5555};
    w0 = wr_pulses; e0 = err_pulses;
    send_frame(f, 32, 12);
    model_frame(f, 32, w);
    checks++; if (err_pulses - e0 !== 1) begin errors++; $display("[TB] FAIL hdr_err_pulses: got %0d expected 1", err_pulses - e0); end
    checks++; if (wr_pulses - w0 !== 0) begin errors++; $display("[TB] FAIL hdr_wr_pulses: got %0d expected 0", wr_pulses - w0); end
    rd_addr = 4'h4; #1;
    checks++; if (rd_data !== model_regs[4]) begin errors++; $display("[TB] FAIL hdr_reg4: got %h expected %h", rd_data, model_regs[4]); end
    checks++; if (err_count !== model_err[7:0]) begin errors++; $display("[TB] FAIL hdr_err_count: got %0d expected %0d", err_count, model_err); end
  endtask

  task automatic test_bad_length();
    int w0, e0;
    bit w;
    logic [63:0] f31, f40;
    f31 = {32'h0, HDR, 4'h2, 16'h7777};
    f40 = {24'h0, 8'hff, HDR, 4'h2, 16'h7777};
    w0 = wr_pulses; e0 = err_pulses;
    send_frame(f31, 31, 12);
    send_frame(f40, 40, 12);
    model_frame(f31, 31, w);
    model_frame(f40, 40, w);
    checks++; if (err_pulses - e0 !== 2) begin errors++; $display("[TB] FAIL len_err_pulses: got %0d expected 2", err_pulses - e0); end
    checks++; if (wr_pulses - w0 !== 0) begin errors++; $display("[TB] FAIL len_wr_pulses: got %0d expected 0", wr_pulses - w0); end
    checks++; if (err_count !== model_err[7:0]) begin errors++; $display("[TB] FAIL len_err_count: got %0d expected %0d", err_count, model_err); end
    rd_addr = 4'h2; #1;
    checks++; if (rd_data !== model_regs[2]) begin errors++; $display("[TB] FAIL len_reg2: got %h expected %h", rd_data, model_regs[2]); end
  endtask

  task automatic test_reset_mid_frame();
    int w0, e0;
    bit w;
    logic [63:0] f;
    f = {32'h0, HDR, 4'h1, 16'habcd};
    w0 = wr_pulses; e0 = err_pulses;
    shift_bits(f >> 16, 16);
    sys_rst_n = 1'b0;
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    model_reset();
    clock_bits(f, 16);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL rst_busy_low_strobe: got %b expected 1", busy); end
    end_frame(12);
    checks++; if (wr_pulses - w0 !== 0) begin errors++; $display("[TB] FAIL rst_wr_pulses: got %0d expected 0", wr_pulses - w0); end
    checks++; if (err_pulses - e0 !== 0) begin errors++; $display("[TB] FAIL rst_err_pulses: got %0d expected 0", err_pulses - e0); end
    checks++; if (err_count !== model_err[7:0]) begin errors++; $display("[TB] FAIL rst_err_count: got %0d expected %0d", err_count, model_err); end
    for (int a = 0; a < 16; a++) begin
      rd_addr = a[3:0];
      #1;
      checks++; if (rd_data !== model_regs[a]) begin errors++; $display("[TB] FAIL rst_reg%0d: got %h expected %h", a, rd_data, model_regs[a]); end
    end
    send_frame(f, 32, 12);
    model_frame(f, 32, w);
    checks++; if (wr_pulses - w0 !== 1) begin errors++; $display("[TB] FAIL rst_refill_pulses: got %0d expected 1", wr_pulses - w0); end
    rd_addr = 4'h1; #1;
    checks++; if (rd_data !== model_regs[1]) begin errors++; $display("[TB] FAIL rst_refill_reg1: got %h expected %h", rd_data, model_regs[1]); end
  endtask

  task automatic test_random();
    int w0, e0, n, pick;
    bit w;
    logic [63:0] f;
    logic [3:0]  a;
    for (int it = 0; it < 24; it++) begin
      pick = $urandom_range(0, 5);
      n = (pick == 0) ? 31 : (pick == 4) ? 33 : (pick == 5) ? 40 : 32;
      f = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) f[31:20] = HDR;
      w0 = wr_pulses; e0 = err_pulses;
      send_frame(f, n, 12);
      model_frame(f, n, w);
      checks++; if (wr_pulses - w0 !== (w ? 1 : 0) || err_pulses - e0 !== (w ? 0 : 1)) begin
        errors++; $display("[TB] FAIL rand%0d_pulses: got wr=%0d err=%0d expected write=%0d", it, wr_pulses - w0, err_pulses - e0, w);
      end
      if (w) begin
        checks++; if (seen_addr !== f[19:16] || seen_data !== f[15:0]) begin errors++; $display("[TB] FAIL rand%0d_write: got %h/%h expected %h/%h", it, seen_addr, seen_data, f[19:16], f[15:0]); end
      end
      checks++; if (err_count !== model_err[7:0]) begin errors++; $display("[TB] FAIL rand%0d_err_count: got %0d expected %0d", it, err_count, model_err); end
      a = 4'($urandom_range(0, 15));
      rd_addr = a; #1;
      checks++; if (rd_data !== model_regs[a]) begin errors++; $display("[TB] FAIL rand%0d_reg%0d: got %h expected %h", it, a, rd_data, model_regs[a]); end
    end
  endtask

  task automatic test_saturation_latency();
    int e0, lat;
    bit w;
    logic [63:0] bad, good;
    bad  = 64'h1;
    good = {32'h0, HDR, 4'h5, 16'h0f0f};
    e0 = err_pulses;
    for (int i = 0; i < 260; i++) begin
      send_frame(bad, 1, 2 * HALF);
      model_frame(bad, 1, w);
    end
    repeat (8) @(negedge sys_clk);
    checks++; if (err_pulses - e0 !== 260) begin errors++; $display("[TB] FAIL sat_err_pulses: got %0d expected 260", err_pulses - e0); end
    checks++; if (err_count !== model_err[7:0]) begin errors++; $display("[TB] FAIL sat_err_count: got %h expected %h", err_count, model_err[7:0]); end

    shift_bits(bad, 1);
    adc3wire_strobe = 1'b1;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge sys_clk); #1;
      if (lat == 0 && frame_err === 1'b1) lat = k;
    end
    model_frame(bad, 1, w);
    checks++; if (lat !== S + 2) begin errors++; $display("[TB] FAIL err_latency: got %0d edges expected %0d", lat, S + 2); end
    checks++; if (err_count !== model_err[7:0]) begin errors++; $display("[TB] FAIL sat_hold: got %h expected %h", err_count, model_err[7:0]); end

    shift_bits(good, 32);
    adc3wire_strobe = 1'b1;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge sys_clk); #1;
      if (lat == 0 && wr_valid === 1'b1) lat = k;
    end
    model_frame(good, 32, w);
    checks++; if (lat !== S + 2) begin errors++; $display("[TB] FAIL wr_latency: got %0d edges expected %0d", lat, S + 2); end
    @(negedge sys_clk);
    rd_addr = 4'h5; #1;
    checks++; if (rd_data !== model_regs[5]) begin errors++; $display("[TB] FAIL lat_reg5: got %h expected %h", rd_data, model_regs[5]); end
  endtask

  initial begin
    $display("[TB] adc3wire_rx bench start");
    test_reset();
    test_single_write();
    test_back_to_back();
    test_bad_header();
    test_bad_length();
    test_reset_mid_frame();
    test_random();
    test_saturation_latency();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
